// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates one single-port RAM between the icache (instruction fetch) and
//   the dcache (load/store). One requester is granted at a time. The grant is
//   held until the RAM reports ACCESS. A one-cycle DONE bubble follows each
//   completion so that a requester still holding its request is not served
//   twice. The caches turn ~iwait / ~dwait into the hit signals that the
//   datapath sees.
//
//   Optional feature (compile-time macro ARB_FAIRNESS_EN):
//     When the macro is defined, a saturating 4-bit streak counter tracks
//     consecutive dcache grants taken while the icache is waiting. Once the
//     streak reaches MAX_DSTREAK, the icache wins the next arbitration.
//     When the macro is undefined, the dcache has strict priority and
//     MAX_DSTREAK only gets a range check.
//
// Parameters
//   WORD_W       data word width
//   ADDR_W       byte address width
//   MAX_DSTREAK  dcache grants allowed in a row while iREN pends (1..15)
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   iREN, iaddr        icache read request / address
//   iload, iwait       instruction word (valid when iwait==0) / icache stall
//   dREN, dWEN         dcache read / write request
//   daddr, dstore      dcache address / write data
//   dload, dwait       load data (valid when dwait==0) / dcache stall
//   ramREN, ramWEN     RAM read / write enable
//   ramaddr, ramstore  RAM address / write data
//   ramload, ramstate  RAM read data / status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//   gnt_d              1 when the current or last grant went to the dcache
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              gnt_d
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    // Catch an out-of-range streak limit at elaboration. Doing this check in
    // every build also keeps the parameter in use when fairness is disabled.
    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_max_dstreak
        $error("mem_arbiter: MAX_DSTREAK must be in 1..15");
    end

    state_t state, state_nxt;
    logic   d_req;
    logic   i_first;   // icache overrides dcache priority in IDLE

    assign d_req = dREN | dWEN;

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_LIM = 4'(MAX_DSTREAK);

    logic [3:0] streak;

    assign i_first = iREN && (streak >= STREAK_LIM);

    // Count only those dcache grants that made a waiting icache wait longer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak <= 4'd0;
        end else if (state == IDLE) begin
            if (state_nxt == IGNT) begin
                streak <= 4'd0;
            end else if (state_nxt == DGNT && iREN && streak != 4'd15) begin
                streak <= streak + 4'd1;
            end
        end
    end
`else
    assign i_first = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt_d <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == DGNT) begin
                gnt_d <= 1'b1;
            end else if (state == IDLE && state_nxt == IGNT) begin
                gnt_d <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iload     = '0;
        dload     = '0;
        iwait     = iREN;
        dwait     = d_req;

        unique case (state)
            IDLE: begin
                if (d_req && !i_first) begin
                    state_nxt = DGNT;
                end else if (iREN) begin
                    state_nxt = IGNT;
                end
            end

            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (iREN && ramstate == RAM_ACCESS) begin
                    iwait     = 1'b0;
                    iload     = ramload;
                    state_nxt = DONE;
                end else if (!iREN) begin
                    state_nxt = IDLE;
                end
            end

            DGNT: begin
                ramaddr = daddr;
                // A write takes precedence when both enables are raised.
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (d_req && ramstate == RAM_ACCESS) begin
                    dwait     = 1'b0;
                    dload     = ramload;
                    state_nxt = DONE;
                end else if (!d_req) begin
                    state_nxt = IDLE;
                end
            end

            DONE: begin
                // No enables this cycle. Any request still held shows as
                // waiting, so the requester cannot see a second completion.
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        gnt_d;

    int total;
    int bad;

    mem_arbiter #(.WORD_W(32), .ADDR_W(32), .MAX_DSTREAK(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .gnt_d    (gnt_d)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        // inputs
        logic        i_ren;
        logic [31:0] i_addr;
        logic        d_ren;
        logic        d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_store;
        logic [31:0] r_load;
        logic [1:0]  r_state;
        // expected outputs
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_dwait;
        logic [31:0] e_dload;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic        e_gntd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
        input logic [1:0] rs,
        input logic eiw, input logic [31:0] eil, input logic edw, input logic [31:0] edl,
        input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] es,
        input logic eg);
        vec_t v;
        v.i_ren = ir; v.i_addr = ia; v.d_ren = dr; v.d_wen = dw;
        v.d_addr = da; v.d_store = ds; v.r_load = rl; v.r_state = rs;
        v.e_iwait = eiw; v.e_iload = eil; v.e_dwait = edw; v.e_dload = edl;
        v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es; v.e_gntd = eg;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        iREN = v.i_ren; iaddr = v.i_addr; dREN = v.d_ren; dWEN = v.d_wen;
        daddr = v.d_addr; dstore = v.d_store; ramload = v.r_load; ramstate = v.r_state;
    endtask

    initial begin
        int  grants;
        int  streak;
        logic exp_d;
        string tag;

        total = 0;
        bad   = 0;

        // ---------------- reset state ----------------
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = 32'h1234; ramstate = 2'd2;
        #3;
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iwait", {31'd0, iwait}, 32'd1);
        check("rst_dwait", {31'd0, dwait}, 32'd0);
        check("rst_gnt_d", {31'd0, gnt_d}, 32'd0);
        check("rst_iload", iload, 32'd0);
        iREN = 1'b0; ramstate = 2'd0; ramload = '0;
        #19 nRST = 1'b1;
        @(posedge CLK); #1;

        // ---------------- table-driven sequence ----------------
        //          iREN iaddr  dR dW daddr  dstore        ramload       rs   | iw iload         dw dload         rR rW raddr  rstore        gd
        // icache read, ACCESS on first grant cycle; request held into DONE
        vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,          1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, 32'h8C010004, 2'd2,   0, 32'h8C010004, 0, 32'h0, 1, 0, 32'h40, 32'h0, 0));
        vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, 32'h8C010004, 2'd2,   1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,           0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        // both request: dcache first, then icache
        vecs.push_back(mk(1, 32'h44, 1, 0, 32'h100, 32'h0, 32'h0, 2'd0,        1, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h44, 1, 0, 32'h100, 32'h0, 32'h11112222, 2'd2, 1, 32'h0, 0, 32'h11112222, 1, 0, 32'h100, 32'h0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,          1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,          1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 0, 32'h0, 32'h0, 32'h33334444, 2'd2,   0, 32'h33334444, 0, 32'h0, 1, 0, 32'h44, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,           0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        // dcache write, BUSY x3 then ACCESS
        vecs.push_back(mk(0, 32'h0, 0, 1, 32'h200, 32'hDEADBEEF, 32'h0, 2'd0,  0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 32'h0, 0, 1, 32'h200, 32'hDEADBEEF, 32'h0, 2'd1, 0, 32'h0, 1, 32'h0, 0, 1, 32'h200, 32'hDEADBEEF, 1));
        vecs.push_back(mk(0, 32'h0, 0, 1, 32'h200, 32'hDEADBEEF, 32'h0, 2'd2,  0, 32'h0, 0, 32'h0, 0, 1, 32'h200, 32'hDEADBEEF, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,           0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1));
        // icache read, ERROR x2 then ACCESS
        vecs.push_back(mk(1, 32'h80, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,          1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(1, 32'h80, 0, 0, 32'h0, 32'h0, 32'hFFFF0000, 2'd3, 1, 32'h0, 0, 32'h0, 1, 0, 32'h80, 32'h0, 0));
        vecs.push_back(mk(1, 32'h80, 0, 0, 32'h0, 32'h0, 32'h12345678, 2'd2,   0, 32'h12345678, 0, 32'h0, 1, 0, 32'h80, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,           0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        // dREN and dWEN together: the write wins
        vecs.push_back(mk(0, 32'h0, 1, 1, 32'h300, 32'h0BADF00D, 32'h0, 2'd0,  0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0, 1, 1, 32'h300, 32'h0BADF00D, 32'h0, 2'd2,  0, 32'h0, 0, 32'h0, 0, 1, 32'h300, 32'h0BADF00D, 1));
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,           0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1));
        // icache drops its request mid-grant: back to IDLE with no DONE bubble
        vecs.push_back(mk(1, 32'h90, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,          1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 32'h90, 0, 0, 32'h0, 32'h0, 32'h0, 2'd1,          0, 32'h0, 0, 32'h0, 1, 0, 32'h90, 32'h0, 0));
        vecs.push_back(mk(1, 32'h94, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,          1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h94, 0, 0, 32'h0, 32'h0, 32'h5, 2'd2,          0, 32'h5, 0, 32'h0, 1, 0, 32'h94, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2'd0,           0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0));

        foreach (vecs[n]) begin
            drive(vecs[n]);
            #4;
            tag = $sformatf("v%0d_", n);
            check({tag, "iwait"},    {31'd0, iwait},  {31'd0, vecs[n].e_iwait});
            check({tag, "iload"},    iload,           vecs[n].e_iload);
            check({tag, "dwait"},    {31'd0, dwait},  {31'd0, vecs[n].e_dwait});
            check({tag, "dload"},    dload,           vecs[n].e_dload);
            check({tag, "ramREN"},   {31'd0, ramREN}, {31'd0, vecs[n].e_ren});
            check({tag, "ramWEN"},   {31'd0, ramWEN}, {31'd0, vecs[n].e_wen});
            check({tag, "ramaddr"},  ramaddr,         vecs[n].e_addr);
            check({tag, "ramstore"}, ramstore,        vecs[n].e_store);
            check({tag, "gnt_d"},    {31'd0, gnt_d},  {31'd0, vecs[n].e_gntd});
            @(posedge CLK); #1;
        end

        // ---------------- async reset in the middle of a write grant ----------------
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        ramstate = 2'd0; ramload = '0;
        @(posedge CLK); #1;
        ramstate = 2'd1;
        #2;
        check("arst_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("arst_pre_gnt_d", {31'd0, gnt_d}, 32'd1);
        nRST = 1'b0;
        #1;
        check("arst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("arst_ramREN", {31'd0, ramREN}, 32'd0);
        check("arst_ramaddr", ramaddr, 32'd0);
        check("arst_gnt_d", {31'd0, gnt_d}, 32'd0);
        check("arst_dwait", {31'd0, dwait}, 32'd1);
        dWEN = 1'b0; ramstate = 2'd0;
        #1 nRST = 1'b1;
        @(posedge CLK); #1;
        check("arst_after_ramWEN", {31'd0, ramWEN}, 32'd0);

        // ---------------- sustained contention ----------------
        iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h800;
        ramstate = 2'd2; ramload = 32'hCAFE0000;
        grants = 0;
        streak = 0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            #4;
            if (ramREN) begin
`ifdef ARB_FAIRNESS_EN
                exp_d = (streak < 4);
                if (exp_d) streak = (streak < 15) ? streak + 1 : 15;
                else streak = 0;
`else
                exp_d = 1'b1;
`endif
                tag = $sformatf("g%0d_", grants);
                check({tag, "gnt_d"},   {31'd0, gnt_d}, {31'd0, exp_d});
                check({tag, "ramaddr"}, ramaddr, exp_d ? 32'h800 : 32'h400);
                check({tag, "iwait"},   {31'd0, iwait}, {31'd0, exp_d});
                grants++;
            end else begin
                check($sformatf("c%0d_iwait_idle", c), {31'd0, iwait}, 32'd1);
            end
            @(posedge CLK); #1;
        end
        check("contention_grants", grants, 32'd10);
        iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
